dct_quant_stream: RTL and testbench
===================================

// Module: dct_quant_stream
// PURPOSE
//  Streaming successor to the fixed-block DCT+quantiser: accepts one 8x8 pixel block over a
//  valid/ready input and computes a 2-D DCT (two 8-term dot-product passes) with fixed-point
//  cosines. It quantises against a runtime-loadable Q table and streams 64 coefficients out,
//  in natural or zigzag order, under backpressure. Sits between block fetch and the entropy coder.
// PARAMETERS
//  PIX_W     8   input pixel width, unsigned; level shift = 2^(PIX_W-1)
//  COEF_FRAC 14  cosine scale 2^COEF_FRAC (replaces *10000 scaling; divide becomes shift)
//  ACC_W     40  signed accumulator width for both passes
//  OUT_W     12  signed quantised coefficient width, saturating
// PORTS
//  Clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      pixel beat valid
//  in_ready   out  1      block accepts pixel beat
//  in_pixel   in   PIX_W  pixel, raster order, row-major, beat 0 = (0,0)
//  zigzag_en  in   1      output order select, sampled on first accepted input beat
//  q_wr_en    in   1      Q table write strobe
//  q_wr_addr  in   6      Q table index (row*8+col)
//  q_wr_data  in   8      Q value, unsigned
//  out_valid  out  1      coefficient beat valid
//  out_ready  in   1      downstream accepts beat
//  out_coef   out  OUT_W  quantised coefficient, signed
//  out_last   out  1      high on beat 63
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; in_ready=0, out_valid=0, out_coef=0, out_last=0;
//   counters cleared; Q table reloaded with the JPEG luma default. In-flight block is discarded.
//  FSM: IDLE -> LOAD -> ROW -> COL -> QUANT -> OUT -> IDLE; 6-bit beat/index counter.
//   IDLE: in_ready=1. First accepted beat -> LOAD (beat counts as pixel 0).
//   LOAD: in_ready=1. Accept until 64th beat, then ROW.
//   ROW:  64 cycles; t[i][j] = rnd(sum_k C[i][k]*(p[k][j]-2^(PIX_W-1))).
//   COL:  64 cycles; r[i][j] = rnd(sum_k t[i][k]*C[j][k]).
//   QUANT: 64 cycles; q[i][j] = sat_OUT_W((|r| + Q/2) / Q) with sign restored.
//    Rounding is half away from zero; Q=0 is treated as 1.
//   OUT: out_valid=1; index advances only on out_valid&&out_ready. out_coef/out_last hold
//    stable while stalled. Beat n = q[n] (natural) or q[zz[n]] (zigzag). IDLE after beat 63.
//  rnd(x) = sign(x)*((|x| + 2^(COEF_FRAC-1)) >> COEF_FRAC). C = round(cos basis * 2^COEF_FRAC).
//  Latency: out_valid rises exactly 193 cycles after the cycle the 64th input beat is accepted.
//  in_ready=0 in ROW..OUT; single block buffer, no overlap. Input valid while busy is ignored.
//  Q writes take effect only in IDLE; writes in any other state are dropped, table unchanged.
//  A Q write and first input beat in the same IDLE cycle: write applies, the block uses new value.
//  Saturation: result beyond OUT_W clamps to +/-(2^(OUT_W-1)-1 / 2^(OUT_W-1)).
// STRUCTURE
//  Package dct_quant_pkg holds the following: the state enum; cosine ROM constants C[8][8] at
//   COEF_FRAC; the default luma Q table; the zigzag index table zz[64].
//  Sub-module dct_dot8 is combinational: 8-term signed dot product plus rnd(). It is instanced
//   once and shared by ROW and COL via an operand mux.
//  Pixel, t, r and q are stored in 64-entry register arrays; the Q divide is a combinational
//   divider, one coefficient per cycle.
// TESTING
//  1 Reset: release reset_n -> in_ready=1, out_valid=0, out_coef=0; assert mid-ROW -> IDLE, no output.
//  2 All pixels 128, default Q -> 64 zeros, out_last only on beat 63, latency 193 cycles.
//  3 All pixels 255 -> beat0=63 (r[0][0]=1015), beats 1..63=0.
//    All pixels 0 -> beat0=-64 (r[0][0]=-1024), others 0.
//  4 Write Q[0]=1 in IDLE, all 255 -> beat0=1015. Write Q[0]=1 during COL -> ignored, beat0=63.
//  5 Q all 1, ramp p[r][c]=128+16c, zigzag_en=1 -> nonzero only at beats {0,1,5,6,14,15,27,28}.
//    The same input with zigzag_en=0 -> nonzero only at beats 0..7.
//  6 out_ready low 10 cycles at beat 20 -> out_coef/out_last stable, all 64 beats delivered once.

Source files
------------

// File: rtl/dct_quant_pkg.sv
// Shared types and constant tables for the streaming DCT + quantiser:
// FSM states, Q14 cosine basis, JPEG luma default Q table and zigzag order.
package dct_quant_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, QUANT, OUT} state_t;

  // Width of stored intermediate values (level-shifted pixels, t, r).
  localparam int DATA_W = 16;
  localparam int CW     = 16;

  // C[i][k] = round(c(i) * cos((2k+1)*i*pi/16) * 2^14), flattened as i*8+k.
  localparam logic signed [CW-1:0] COS_TAB [64] = '{
    16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
    16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
    16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
    16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
    16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
    16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
    16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
    16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
  };

  localparam logic [7:0] Q_DEFAULT [64] = '{
    8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
    8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
    8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
    8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
    8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
    8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
    8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
    8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
  };

  // Natural (row*8+col) index of the n-th coefficient in zigzag order.
  localparam logic [5:0] ZZ_TAB [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dct_dot8.sv
// Combinational 8-term signed dot product followed by symmetric rounding
// (half away from zero) that removes the cosine scale.
module dct_dot8
  import dct_quant_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int COEF_FRAC = 14
)(
  input  logic [7:0][DATA_W-1:0] data,
  input  logic [7:0][CW-1:0]     coef,
  output logic [DATA_W-1:0]      result
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (COEF_FRAC - 1));

  logic signed [ACC_W-1:0] dExt [8];
  logic signed [ACC_W-1:0] cExt [8];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] mag;
  logic signed [ACC_W-1:0] rounded;

  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      dExt[k] = ACC_W'(signed'(data[k]));
      cExt[k] = ACC_W'(signed'(coef[k]));
      acc     = acc + dExt[k] * cExt[k];
    end
    mag     = acc[ACC_W-1] ? -acc : acc;
    rounded = (mag + HALF) >> COEF_FRAC;
    result  = acc[ACC_W-1] ? DATA_W'(-rounded) : DATA_W'(rounded);
  end

endmodule

// File: rtl/dct_quant_stream.sv
// Streaming 8x8 DCT + quantiser: loads one block, runs row and column passes
// through a shared dot-product unit, quantises, then streams 64 coefficients.
module dct_quant_stream
  import dct_quant_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 12
)(
  input  logic             Clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             zigzag_en,
  input  logic             q_wr_en,
  input  logic [5:0]       q_wr_addr,
  input  logic [7:0]       q_wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_coef,
  output logic             out_last
);

  localparam int SAT_W = DATA_W + 1;
  localparam logic [DATA_W-1:0] LEVEL    = DATA_W'(2 ** (PIX_W - 1));
  localparam logic [SAT_W-1:0]  MAG_POS  = SAT_W'(2 ** (OUT_W - 1) - 1);
  localparam logic [SAT_W-1:0]  MAG_NEG  = SAT_W'(2 ** (OUT_W - 1));
  localparam logic [OUT_W-1:0]  MAX_CODE = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};

  state_t state;
  logic [5:0] idx;
  logic       zigSel;

  logic [PIX_W-1:0]  pixMem [64];
  logic [DATA_W-1:0] tMem   [64];
  logic [DATA_W-1:0] rMem   [64];
  logic [OUT_W-1:0]  qMem   [64];
  logic [7:0]        qTab   [64];

  logic accept;
  assign accept = in_valid && in_ready && (state == IDLE || state == LOAD);

  // ROW walks p down column j against basis row i; COL walks t across row i against basis row j.
  logic [7:0][DATA_W-1:0] dotData;
  logic [7:0][CW-1:0]     dotCoef;
  logic [DATA_W-1:0]      dotResult;
  logic [2:0]             rowI;
  logic [2:0]             colJ;

  always_comb begin
    rowI = idx[5:3];
    colJ = idx[2:0];
    for (int k = 0; k < 8; k++) begin
      if (state == COL) begin
        dotData[k] = tMem[{rowI, 3'(k)}];
        dotCoef[k] = COS_TAB[{colJ, 3'(k)}];
      end else begin
        dotData[k] = DATA_W'(pixMem[{3'(k), colJ}]) - LEVEL;
        dotCoef[k] = COS_TAB[{rowI, 3'(k)}];
      end
    end
  end

  dct_dot8 #(.ACC_W(ACC_W), .COEF_FRAC(COEF_FRAC)) dotUnit (
    .data   (dotData),
    .coef   (dotCoef),
    .result (dotResult)
  );

  // Quantise magnitude with half-away-from-zero rounding, then restore sign and saturate.
  logic [DATA_W-1:0] rVal;
  logic              rNeg;
  logic [SAT_W-1:0]  rMag;
  logic [SAT_W-1:0]  quo;
  logic [SAT_W-1:0]  negQuo;
  logic [7:0]        qDiv;
  logic [OUT_W-1:0]  qVal;

  always_comb begin
    rVal   = rMem[idx];
    rNeg   = rVal[DATA_W-1];
    rMag   = rNeg ? {1'b0, -rVal} : {1'b0, rVal};
    qDiv   = (qTab[idx] == 8'd0) ? 8'd1 : qTab[idx];
    quo    = (rMag + {{(SAT_W-7){1'b0}}, qDiv[7:1]}) / {{(SAT_W-8){1'b0}}, qDiv};
    negQuo = -quo;
    if (rNeg) qVal = (quo > MAG_NEG) ? MIN_CODE : negQuo[OUT_W-1:0];
    else      qVal = (quo > MAG_POS) ? MAX_CODE : quo[OUT_W-1:0];
  end

  // Address of the next beat to present: current index while priming, else the following one.
  logic [5:0] idxNext;
  logic [5:0] beatSel;
  logic [5:0] beatAddr;

  always_comb begin
    idxNext  = idx + 6'd1;
    beatSel  = out_valid ? idxNext : idx;
    beatAddr = zigSel ? ZZ_TAB[beatSel] : beatSel;
  end

  always_ff @(posedge Clock) begin
    if (accept)           pixMem[idx] <= in_pixel;
    if (state == ROW)     tMem[idx]   <= dotResult;
    if (state == COL)     rMem[idx]   <= dotResult;
    if (state == QUANT)   qMem[idx]   <= qVal;
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < 64; a++) qTab[a] <= Q_DEFAULT[a];
    end else if (q_wr_en && state == IDLE) begin
      qTab[q_wr_addr] <= q_wr_data;
    end
  end

  // OUT spends one cycle priming the output register before the first beat is offered.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      zigSel    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          idx      <= '0;
          if (accept) begin
            zigSel <= zigzag_en;
            idx    <= 6'd1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            idx <= idxNext;
            if (idx == 6'd63) begin
              in_ready <= 1'b0;
              state    <= ROW;
            end
          end
        end
        ROW: begin
          idx <= idxNext;
          if (idx == 6'd63) state <= COL;
        end
        COL: begin
          idx <= idxNext;
          if (idx == 6'd63) state <= QUANT;
        end
        QUANT: begin
          idx <= idxNext;
          if (idx == 6'd63) state <= OUT;
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_coef  <= qMem[beatAddr];
            out_last  <= 1'b0;
          end else if (out_ready) begin
            if (idx == 6'd63) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              idx       <= '0;
              state     <= IDLE;
            end else begin
              idx      <= idxNext;
              out_coef <= qMem[beatAddr];
              out_last <= (idxNext == 6'd63);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_quant_stream.sv
// Scoreboard bench for dct_quant_stream: an integer reference model of the
// 2-D DCT and quantiser predicts every beat, compared as the DUT streams out.
module tb_dct_quant_stream;

  logic        Clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        zigzag_en;
  logic        q_wr_en;
  logic [5:0]  q_wr_addr;
  logic [7:0]  q_wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coef;
  logic        out_last;

  dct_quant_stream dut (
    .Clock     (Clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .zigzag_en (zigzag_en),
    .q_wr_en   (q_wr_en),
    .q_wr_addr (q_wr_addr),
    .q_wr_data (q_wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_last  (out_last)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {int coef; int last;} beat_t;
  beat_t sb[$];

  int testsRun    = 0;
  int testsFailed = 0;

  int pixBuf [64];
  int qModel [64];
  int cosM   [8][8];
  int zzTab  [64];
  int qDefault [64] = '{16, 11, 10, 16, 24, 40, 51, 61,  12, 12, 14, 19, 26, 58, 60, 55,
                        14, 13, 16, 24, 40, 57, 69, 56,  14, 17, 22, 29, 51, 87, 80, 62,
                        18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                        49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};

  int firstCoef;
  int nzCount;
  bit patternOn;
  logic [63:0] nzMask;

  task automatic checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint rndM(input longint x);
    if (x < 0) return -((-x + 8192) / 16384);
    return (x + 8192) / 16384;
  endfunction

  task automatic initTables();
    real pi = 3.14159265358979;
    real ci, v;
    int n = 0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        ci = (i == 0) ? $sqrt(0.125) : 0.5;
        v  = ci * $cos((2 * k + 1) * i * pi / 16.0) * 16384.0;
        cosM[i][k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zzTab[n] = r * 8 + (s - r); n++; end
      else            for (int r = lo; r <= hi; r++) begin zzTab[n] = r * 8 + (s - r); n++; end
    end
    for (int a = 0; a < 64; a++) qModel[a] = qDefault[a];
  endtask

  // Reference 2-D DCT + quantiser; pushes beats in the order the DUT must emit them.
  task automatic buildExpected(input bit zig);
    longint acc;
    int t [8][8];
    int r [8][8];
    int qn [64];
    int qq, mag, quo, v;
    beat_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(cosM[i][k]) * (pixBuf[k * 8 + j] - 128);
        t[i][j] = int'(rndM(acc));
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(t[i][k]) * cosM[j][k];
        r[i][j] = int'(rndM(acc));
      end
    for (int n = 0; n < 64; n++) begin
      qq  = (qModel[n] == 0) ? 1 : qModel[n];
      mag = (r[n / 8][n % 8] < 0) ? -r[n / 8][n % 8] : r[n / 8][n % 8];
      quo = (mag + qq / 2) / qq;
      v   = (r[n / 8][n % 8] < 0) ? -quo : quo;
      if (v > 2047) v = 2047;
      if (v < -2048) v = -2048;
      qn[n] = v;
    end
    for (int n = 0; n < 64; n++) begin
      b.coef = zig ? qn[zzTab[n]] : qn[n];
      b.last = (n == 63);
      sb.push_back(b);
    end
  endtask

  task automatic writeQ(input int addr, input int data);
    @(negedge Clock);
    q_wr_en = 1'b1; q_wr_addr = 6'(addr); q_wr_data = 8'(data);
    @(negedge Clock);
    q_wr_en = 1'b0;
    qModel[addr] = data;
  endtask

  // Sends pixBuf as one block; optionally writes the Q table alongside the first beat.
  task automatic applyStimulus(input bit zig, input bit qwEn, input int qwAddr, input int qwData,
                               input bit push);
    int b = 0;
    int guard = 0;
    bit accepted;
    if (qwEn) qModel[qwAddr] = qwData;
    if (push) buildExpected(zig);
    while (b < 64 && guard < 500) begin
      @(negedge Clock);
      in_valid  = 1'b1;
      in_pixel  = 8'(pixBuf[b]);
      zigzag_en = zig;
      q_wr_en   = qwEn && (b == 0);
      q_wr_addr = 6'(qwAddr);
      q_wr_data = 8'(qwData);
      accepted  = in_ready;
      @(posedge Clock);
      if (accepted) b++;
      guard++;
    end
    #1;
    in_valid = 1'b0;
    q_wr_en  = 1'b0;
    checkOutput("beatsAccepted", b, 64);
  endtask

  task automatic receiveBlock(input int stallBeat, input int qWrCycle);
    int cyc = 0;
    int beats = 0;
    int stallCnt = 0;
    int heldCoef = 0;
    int heldLast = 0;
    bit seen = 0;
    beat_t e;
    out_ready = 1'b1;
    nzCount = 0;
    firstCoef = 9999;
    while (beats < 64 && cyc < 1000) begin
      @(posedge Clock);
      cyc++;
      #1;
      if (qWrCycle > 0) begin
        q_wr_en = (cyc == qWrCycle); q_wr_addr = 6'd0; q_wr_data = 8'd1;
      end
      @(negedge Clock);
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          checkOutput("latency", cyc, 193);
        end
        if (beats == stallBeat && stallCnt < 10) begin
          if (stallCnt == 0) begin
            heldCoef = int'($signed(out_coef));
            heldLast = int'(out_last);
          end else begin
            checkOutput("stallCoef", int'($signed(out_coef)), heldCoef);
            checkOutput("stallLast", int'(out_last), heldLast);
          end
          out_ready = 1'b0;
          stallCnt++;
        end else begin
          if (beats == stallBeat) begin
            checkOutput("stallCoef", int'($signed(out_coef)), heldCoef);
            stallCnt++;
          end
          out_ready = 1'b1;
          if (sb.size() > 0) e = sb.pop_front();
          else begin e.coef = 9999; e.last = 0; end
          checkOutput("coef", int'($signed(out_coef)), e.coef);
          checkOutput("last", int'(out_last), e.last);
          if (beats == 0) firstCoef = int'($signed(out_coef));
          if (out_coef != 12'd0) nzCount++;
          if (patternOn && !nzMask[beats]) checkOutput("zeroPattern", int'($signed(out_coef)), 0);
          beats++;
        end
      end
    end
    q_wr_en = 1'b0;
    checkOutput("beatCount", beats, 64);
    checkOutput("sbLeft", sb.size(), 0);
    sb.delete();
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("validDrop", int'(out_valid), 0);
  endtask

  task automatic fillConst(input int v);
    for (int a = 0; a < 64; a++) pixBuf[a] = v;
  endtask

  initial begin
    bit seenOut;
    initTables();
    in_valid = 0; in_pixel = 0; zigzag_en = 0; q_wr_en = 0; q_wr_addr = 0; q_wr_data = 0;
    out_ready = 1; patternOn = 0; nzMask = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checkOutput("rstInReady", int'(in_ready), 0);
    checkOutput("rstOutValid", int'(out_valid), 0);
    checkOutput("rstOutCoef", int'(out_coef), 0);
    reset_n = 1'b1;
    @(negedge Clock);
    checkOutput("idleInReady", int'(in_ready), 1);
    checkOutput("idleOutValid", int'(out_valid), 0);
    checkOutput("idleOutCoef", int'(out_coef), 0);

    // Reset asserted while the row pass is running must discard the block.
    fillConst(200);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    repeat (10) @(posedge Clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midRstInReady", int'(in_ready), 0);
    checkOutput("midRstOutValid", int'(out_valid), 0);
    @(negedge Clock);
    reset_n = 1'b1;
    seenOut = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clock);
      if (out_valid) seenOut = 1;
    end
    checkOutput("noOutAfterRst", int'(seenOut), 0);
    checkOutput("readyAfterRst", int'(in_ready), 1);

    fillConst(128);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    receiveBlock(-1, 0);
    checkOutput("flatNonzero", nzCount, 0);

    fillConst(255);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    receiveBlock(-1, 0);
    checkOutput("white0", firstCoef, 63);
    checkOutput("whiteNonzero", nzCount, 1);

    fillConst(0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    receiveBlock(-1, 0);
    checkOutput("black0", firstCoef, -64);

    // Q write landing in the column pass must be dropped.
    fillConst(255);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    receiveBlock(-1, 70);
    checkOutput("colWrIgnored", firstCoef, 63);

    // Q write on the same cycle as the first pixel applies to that block.
    applyStimulus(1'b0, 1'b1, 0, 1, 1'b1);
    receiveBlock(-1, 0);
    checkOutput("q1White0", firstCoef, 1015);

    for (int a = 0; a < 64; a++) writeQ(a, 1);
    for (int a = 0; a < 64; a++) pixBuf[a] = 128 + 16 * (a % 8);
    nzMask = '0;
    nzMask[0] = 1; nzMask[1] = 1; nzMask[5] = 1; nzMask[6] = 1;
    nzMask[14] = 1; nzMask[15] = 1; nzMask[27] = 1; nzMask[28] = 1;
    patternOn = 1;
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    receiveBlock(-1, 0);
    nzMask = 64'h0000_0000_0000_00FF;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    receiveBlock(-1, 0);
    patternOn = 0;

    // Reset reloads the default table; then a random block under backpressure.
    @(negedge Clock);
    reset_n = 1'b0;
    for (int a = 0; a < 64; a++) qModel[a] = qDefault[a];
    @(negedge Clock);
    reset_n = 1'b1;
    for (int a = 0; a < 64; a++) pixBuf[a] = int'($urandom_range(0, 255));
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    receiveBlock(20, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
